// File: rtl/echo_mixer.sv
`timescale 1ns/1ps
// Echo mixer: for each dry sample, mixes in the delayed sample scaled by two
// signed Q1.(GAIN_WIDTH-1) gains. A single shared multiplier produces the wet
// mix output and then the feedback sample for the delay line, both saturated.
module echo_mixer #(
    parameter int DATA_WIDTH = 32,
    parameter int GAIN_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] dry_in,
    input  logic                  dry_valid,
    input  logic [DATA_WIDTH-1:0] dly_in,
    input  logic                  dly_valid,
    input  logic [GAIN_WIDTH-1:0] wet_gain,
    input  logic [GAIN_WIDTH-1:0] fb_gain,
    output logic [DATA_WIDTH-1:0] mix_out,
    output logic                  mix_valid,
    output logic [DATA_WIDTH-1:0] fb_out,
    output logic                  fb_wr_en,
    output logic                  busy,
    output logic                  overrun
);

    // Product is full width; the sum carries two guard bits so that a
    // full-scale negative sample times a full-scale negative gain added to a
    // full-scale dry sample still cannot wrap before saturation.
    localparam int PW = DATA_WIDTH + GAIN_WIDTH;
    localparam int SW = DATA_WIDTH + 2;

    localparam logic signed [SW-1:0] SUM_MAX = {3'b000, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SUM_MIN = {3'b111, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MUL_WET,
        MUL_FB,
        DONE
    } state_t;

    state_t state, next_state;

    logic [DATA_WIDTH-1:0]  dry_q;
    logic [DATA_WIDTH-1:0]  dly_q;
    logic [GAIN_WIDTH-1:0]  wet_q;
    logic [GAIN_WIDTH-1:0]  fb_q;

    logic                   accept;
    logic                   load_mix;
    logic                   load_fb;

    logic [GAIN_WIDTH-1:0]  gain_sel;
    logic signed [PW-1:0]   product;
    logic signed [SW-1:0]   scaled;
    logic signed [SW-1:0]   sum;
    logic [DATA_WIDTH-1:0]  sat_val;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: only IDLE waits for input, the rest step unconditionally.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (dry_valid) next_state = MUL_WET;
            MUL_WET: next_state = MUL_FB;
            MUL_FB:  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State decode into busy flag and datapath load enables.
    always_comb begin
        busy     = (state != IDLE);
        accept   = (state == IDLE) && dry_valid;
        load_mix = (state == MUL_WET);
        load_fb  = (state == MUL_FB);
    end

    // Shared multiplier, floor-scaling shift, widened add and saturation.
    always_comb begin
        gain_sel = load_mix ? wet_q : fb_q;
        product  = $signed({{GAIN_WIDTH{dly_q[DATA_WIDTH-1]}}, dly_q})
                 * $signed({{DATA_WIDTH{gain_sel[GAIN_WIDTH-1]}}, gain_sel});
        scaled   = SW'(product >>> (GAIN_WIDTH - 1));
        sum      = SW'($signed(dry_q)) + scaled;
        if (sum > SUM_MAX) begin
            sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (sum < SUM_MIN) begin
            sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            sat_val = sum[DATA_WIDTH-1:0];
        end
    end

    // Capture operands on acceptance so later input changes cannot disturb the sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dry_q <= '0;
            dly_q <= '0;
            wet_q <= '0;
            fb_q  <= '0;
        end else if (accept) begin
            dry_q <= dry_in;
            dly_q <= dly_valid ? dly_in : '0;
            wet_q <= wet_gain;
            fb_q  <= fb_gain;
        end
    end

    // Result registers and the DONE-cycle strobes (DONE always follows MUL_FB).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix_out   <= '0;
            fb_out    <= '0;
            mix_valid <= 1'b0;
            fb_wr_en  <= 1'b0;
        end else begin
            if (load_mix) mix_out <= sat_val;
            if (load_fb)  fb_out  <= sat_val;
            mix_valid <= load_fb;
            fb_wr_en  <= load_fb;
        end
    end

    // Sticky flag for samples dropped because the mixer was still busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (dry_valid && busy) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_echo_mixer.sv
`timescale 1ns/1ps
// Testbench for echo_mixer: directed corner cases plus randomized samples,
// checked against an arithmetic model of the mix/feedback equations.
module tb_echo_mixer;

    logic        clk;
    logic        rst_n;
    logic [31:0] dry_in;
    logic        dry_valid;
    logic [31:0] dly_in;
    logic        dly_valid;
    logic [15:0] wet_gain;
    logic [15:0] fb_gain;
    logic [31:0] mix_out;
    logic        mix_valid;
    logic [31:0] fb_out;
    logic        fb_wr_en;
    logic        busy;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    logic [31:0] expMixPrev = 32'd0;
    logic [31:0] expFbPrev  = 32'd0;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    echo_mixer #(.DATA_WIDTH(32), .GAIN_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dry_in    (dry_in),
        .dry_valid (dry_valid),
        .dly_in    (dly_in),
        .dly_valid (dly_valid),
        .wet_gain  (wet_gain),
        .fb_gain   (fb_gain),
        .mix_out   (mix_out),
        .mix_valid (mix_valid),
        .fb_out    (fb_out),
        .fb_wr_en  (fb_wr_en),
        .busy      (busy),
        .overrun   (overrun)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // dry + floor(dly * gain / 2^15), clamped to the 32-bit signed range.
    function automatic logic [31:0] mixModel(input logic [31:0] dry, input logic [31:0] dly,
                                             input logic [15:0] gain);
        longint d, l, g, p, q, s;
        d = longint'($signed(dry));
        l = longint'($signed(dly));
        g = longint'($signed(gain));
        p = l * g;
        q = p / 32768;
        if ((p % 32768) != 0 && p < 0) q = q - 1;
        s = d + q;
        if (s > SMAX) s = SMAX;
        if (s < SMIN) s = SMIN;
        return s[31:0];
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Presents one dry sample, optionally fires a second pulse while busy
    // (dropAt = 1..3 cycles after acceptance), and checks the whole transaction.
    task automatic applyStimulus(input string tag, input logic [31:0] dry, input logic [31:0] dly,
                                 input logic dlyv, input logic [15:0] wet, input logic [15:0] fb,
                                 input int dropAt);
        logic [31:0] dlyEff, expMix, expFb;
        dlyEff = dlyv ? dly : 32'd0;
        expMix = mixModel(dry, dlyEff, wet);
        expFb  = mixModel(dry, dlyEff, fb);

        @(negedge clk);
        dry_in    = dry;
        dly_in    = dly;
        dly_valid = dlyv;
        wet_gain  = wet;
        fb_gain   = fb;
        dry_valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, ".busy_accept"}, {31'd0, busy}, 32'd1);

        for (int k = 1; k <= 3; k++) begin
            dry_valid = (k == dropAt);
            dry_in    = $urandom;
            dly_in    = $urandom;
            dly_valid = 1'($urandom_range(0, 1));
            wet_gain  = 16'($urandom);
            fb_gain   = 16'($urandom);
            @(posedge clk);
            #1;
            if (k == 1) begin
                checkOutput({tag, ".strobe_c1"}, {30'd0, mix_valid, fb_wr_en}, 32'd0);
                checkOutput({tag, ".fb_hold"}, fb_out, expFbPrev);
            end else if (k == 2) begin
                checkOutput({tag, ".strobe_done"}, {30'd0, mix_valid, fb_wr_en}, 32'd3);
                checkOutput({tag, ".mix_out"}, mix_out, expMix);
                checkOutput({tag, ".fb_out"}, fb_out, expFb);
                checkOutput({tag, ".busy_done"}, {31'd0, busy}, 32'd1);
            end else begin
                checkOutput({tag, ".strobe_after"}, {30'd0, mix_valid, fb_wr_en}, 32'd0);
                checkOutput({tag, ".busy_idle"}, {31'd0, busy}, 32'd0);
                checkOutput({tag, ".mix_hold"}, mix_out, expMix);
            end
        end
        dry_valid = 1'b0;
        expMixPrev = expMix;
        expFbPrev  = expFb;
    endtask

    // Main sequence: reset, directed corners, overrun, mid-op reset, random.
    initial begin
        logic [15:0] gpick [4];
        rst_n     = 1'b0;
        dry_in    = '0;
        dry_valid = 1'b0;
        dly_in    = '0;
        dly_valid = 1'b0;
        wet_gain  = '0;
        fb_gain   = '0;

        #3;
        checkOutput("rst.mix_out", mix_out, 32'd0);
        checkOutput("rst.fb_out", fb_out, 32'd0);
        checkOutput("rst.strobes", {30'd0, mix_valid, fb_wr_en}, 32'd0);
        checkOutput("rst.busy", {31'd0, busy}, 32'd0);
        checkOutput("rst.overrun", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("basic", 32'd1000, 32'd2000, 1'b1, 16'h4000, 16'h2000, 0);
        applyStimulus("sat_pos", 32'h7FFFFF00, 32'h7FFFFFFF, 1'b1, 16'h7FFF, 16'h7FFF, 0);
        applyStimulus("sat_neg", 32'h80000100, 32'h80000000, 1'b1, 16'h7FFF, 16'h7FFF, 0);
        applyStimulus("floor", 32'd0, 32'hFFFFFFFD, 1'b1, 16'h4000, 16'h4000, 0);
        applyStimulus("no_dly", 32'd77, 32'd5000, 1'b0, 16'h7FFF, 16'h4000, 0);
        applyStimulus("negneg", 32'h7FFFFFFF, 32'h80000000, 1'b1, 16'h8000, 16'h8000, 0);
        checkOutput("overrun_clear", {31'd0, overrun}, 32'd0);

        applyStimulus("drop2", 32'd12345, 32'hFFFF0000, 1'b1, 16'h2000, 16'hC000, 2);
        checkOutput("overrun_set", {31'd0, overrun}, 32'd1);
        applyStimulus("drop_done", 32'hFFFFF000, 32'd999, 1'b1, 16'h6000, 16'h1000, 3);
        applyStimulus("after_drop", 32'd500, 32'd400, 1'b1, 16'h4000, 16'h4000, 0);
        checkOutput("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Reset while the sample sits in MUL_FB.
        @(negedge clk);
        dry_in    = 32'd42;
        dly_in    = 32'd4242;
        dly_valid = 1'b1;
        wet_gain  = 16'h4000;
        fb_gain   = 16'h4000;
        dry_valid = 1'b1;
        @(posedge clk);
        #1;
        dry_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst.mix_out", mix_out, 32'd0);
        checkOutput("midrst.fb_out", fb_out, 32'd0);
        checkOutput("midrst.strobes", {30'd0, mix_valid, fb_wr_en}, 32'd0);
        checkOutput("midrst.busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst.overrun", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        expMixPrev = 32'd0;
        expFbPrev  = 32'd0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput("midrst.no_strobe", {29'd0, busy, mix_valid, fb_wr_en}, 32'd0);
        end
        applyStimulus("post_rst", 32'hFFFFFC18, 32'd3000, 1'b1, 16'h4000, 16'hE000, 0);

        // Randomized samples, biased towards full-scale gains and samples.
        gpick[0] = 16'h7FFF;
        gpick[1] = 16'h8000;
        gpick[2] = 16'h0000;
        gpick[3] = 16'h4000;
        for (int i = 0; i < 40; i++) begin
            logic [31:0] rd, rl;
            logic [15:0] rw, rf;
            rd = $urandom;
            rl = $urandom;
            if ($urandom_range(0, 3) == 0) rd = {rd[31], {31{~rd[31]}}};
            if ($urandom_range(0, 3) == 0) rl = {rl[31], {31{~rl[31]}}};
            rw = ($urandom_range(0, 2) == 0) ? gpick[$urandom_range(0, 3)] : 16'($urandom);
            rf = ($urandom_range(0, 2) == 0) ? gpick[$urandom_range(0, 3)] : 16'($urandom);
            applyStimulus($sformatf("rand%0d", i), rd, rl, 1'($urandom_range(0, 1)), rw, rf,
                          ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
